dump_sequencer: RTL

Sequences a debug dump of processor state onto the UART transmitter: the program counter, then the 32 register-bank words, then the 128 data-memory bytes. Each section is optional. The block sits between the datapath read ports (PC value, register bank, data memory) and the UART TX byte interface. The debug control FSM drives it with a one-cycle start and a section mask, and waits for the done pulse.

---
 rtl/dump_sequencer_if.sv | 26 ++
 rtl/dump_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dump_sequencer_if.sv
// dump_sequencer_if: datapath read ports and UART TX byte handshake seen by the dump sequencer
interface dump_sequencer_if #(
    parameter int NB_DATA    = 8,
    parameter int NB_ADDR    = 32,
    parameter int NB_ADDR_RB = 5,
    parameter int NB_ADDR_DM = 7
);
    logic [NB_ADDR-1:0]    pc_value;
    logic [NB_ADDR_RB-1:0] rb_addr;
    logic                  rb_read_enable;
    logic [NB_ADDR-1:0]    rb_data;
    logic [NB_ADDR_DM-1:0] dm_addr;
    logic                  dm_read_enable;
    logic [NB_DATA-1:0]    dm_data;
    logic [NB_DATA-1:0]    tx_data;
    logic                  tx_start;
    logic                  tx_done;
    modport master (
        input  pc_value, rb_data, dm_data, tx_done,
        output rb_addr, rb_read_enable, dm_addr, dm_read_enable, tx_data, tx_start
    );
    modport slave (
        output pc_value, rb_data, dm_data, tx_done,
        input  rb_addr, rb_read_enable, dm_addr, dm_read_enable, tx_data, tx_start
    );
endinterface

// File: rtl/dump_sequencer.sv
// dump_sequencer: streams PC, register bank and data memory bytes MSB first to the UART; DUMP_CHECKSUM_EN appends an XOR checksum byte
module dump_sequencer #(
    parameter int NB_DATA    = 8,
    parameter int NB_ADDR    = 32,
    parameter int NB_ADDR_RB = 5,
    parameter int NB_ADDR_DM = 7,
    parameter int RB_DEPTH   = 32,
    parameter int DM_DEPTH   = 128
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [2:0]        i_sel,
    output logic              o_busy,
    output logic              o_done,
    dump_sequencer_if.master  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] NEXT  = 3'd5;
    localparam logic [2:0] DONE  = 3'd7;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] CSUM  = 3'd6;
    localparam logic [2:0] TAIL  = CSUM;
`else
    localparam logic [2:0] TAIL  = DONE;
`endif
    localparam logic [1:0] SEC_PC = 2'd0;
    localparam logic [1:0] SEC_RB = 2'd1;
    localparam logic [1:0] SEC_DM = 2'd2;

    logic [2:0]            state_q, state_d;
    logic [2:0]            sel_q, sel_d;
    logic [1:0]            sec_q, sec_d;
    logic [NB_ADDR_RB-1:0] rb_addr_q, rb_addr_d;
    logic [NB_ADDR_DM-1:0] dm_addr_q, dm_addr_d;
    logic [NB_ADDR-1:0]    shift_q, shift_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [NB_DATA-1:0]    tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  rb_re_q, rb_re_d;
    logic                  dm_re_q, dm_re_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [2:0]            rest;
    logic                  more;
    logic [2:0]            word_end;
`ifdef DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0]    csum_q, csum_d;
    logic                  last_q, last_d;
    assign word_end = last_q ? DONE : NEXT;
`else
    assign word_end = NEXT;
`endif

    // sections still pending after the current one, and whether the current one has entries left
    assign rest = sel_q & (sec_q == SEC_PC ? 3'b110 : sec_q == SEC_RB ? 3'b100 : 3'b000);
    assign more = sec_q == SEC_RB ? rb_addr_q != NB_ADDR_RB'(RB_DEPTH - 1) :
                  sec_q == SEC_DM ? dm_addr_q != NB_ADDR_DM'(DM_DEPTH - 1) : 1'b0;

    // next-state and registered-output logic; outputs are derived from the next state
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sec_d     = sec_q;
        rb_addr_d = rb_addr_q;
        dm_addr_d = dm_addr_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d    = csum_q;
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: if (i_start) begin
                sel_d     = i_sel;
                rb_addr_d = '0;
                dm_addr_d = '0;
                sec_d     = i_sel[0] ? SEC_PC : i_sel[1] ? SEC_RB : SEC_DM;
                state_d   = |i_sel ? FETCH : TAIL;
`ifdef DUMP_CHECKSUM_EN
                csum_d    = '0;
                last_d    = 1'b0;
`endif
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                shift_d = sec_q == SEC_PC ? bus.pc_value :
                          sec_q == SEC_RB ? bus.rb_data :
                          {bus.dm_data, {(NB_ADDR - NB_DATA){1'b0}}};
                cnt_d   = sec_q == SEC_DM ? 2'd0 : 2'd3;
                state_d = SEND;
            end
            SEND: begin
`ifdef DUMP_CHECKSUM_EN
                csum_d  = last_q ? csum_q : csum_q ^ tx_data_q;
`endif
                state_d = WAIT;
            end
            WAIT: if (bus.tx_done) begin
                shift_d = cnt_q != 2'd0 ? shift_q << NB_DATA : shift_q;
                cnt_d   = cnt_q != 2'd0 ? cnt_q - 2'd1 : cnt_q;
                state_d = cnt_q != 2'd0 ? SEND : word_end;
            end
            NEXT: begin
                rb_addr_d = sec_q == SEC_RB ? rb_addr_q + 1'b1 : rb_addr_q;
                dm_addr_d = sec_q == SEC_DM ? dm_addr_q + 1'b1 : dm_addr_q;
                sec_d     = more ? sec_q : rest[1] ? SEC_RB : SEC_DM;
                state_d   = more || |rest ? FETCH : TAIL;
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
                shift_d = {csum_q, {(NB_ADDR - NB_DATA){1'b0}}};
                cnt_d   = 2'd0;
                last_d  = 1'b1;
                state_d = SEND;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tx_start_d = state_d == SEND;
        tx_data_d  = state_d == SEND ? shift_d[NB_ADDR-1 -: NB_DATA] : tx_data_q;
        rb_re_d    = (state_d == FETCH || state_d == LOAD) && sec_d == SEC_RB;
        dm_re_d    = (state_d == FETCH || state_d == LOAD) && sec_d == SEC_DM;
        busy_d     = state_d != IDLE;
        done_d     = state_q == DONE;
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            sec_q      <= '0;
            rb_addr_q  <= '0;
            dm_addr_q  <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            rb_re_q    <= 1'b0;
            dm_re_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= '0;
            last_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            sec_q      <= sec_d;
            rb_addr_q  <= rb_addr_d;
            dm_addr_q  <= dm_addr_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            rb_re_q    <= rb_re_d;
            dm_re_q    <= dm_re_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
            last_q     <= last_d;
`endif
        end
    end

    assign bus.rb_addr        = rb_addr_q;
    assign bus.rb_read_enable = rb_re_q;
    assign bus.dm_addr        = dm_addr_q;
    assign bus.dm_read_enable = dm_re_q;
    assign bus.tx_data        = tx_data_q;
    assign bus.tx_start       = tx_start_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
endmodule
